quantizador: RTL

- Forward quantizer: the encoder-side counterpart of the reescalador (inverse quantizer/rescaler).
- Consumes a stream of 4x4 integer-transform coefficients, 16 per block in raster order.
- Emits H.264-style quantized levels plus a per-block nonzero count, feeding the entropy coder.
- Pipelined, with valid/ready handshakes on both sides.

---
 rtl/quantizador.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/quantizador.sv
// Forward quantizer for 4x4 transform blocks: Z = sign(W) * ((|W| * MF + f) >> qbits),
// with per-block QP/intra latched at position 0 and a nonzero count on the last level.
module quantizador #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_coef,
  input  logic [5:0]               in_qp,
  input  logic                     in_intra,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  out_level,
  output logic                     out_last,
  output logic [4:0]               out_nz
);

  localparam int COEF_W = 14;
  localparam int PROD_W = 30;
  localparam int SUM_W  = 31;
  localparam int OFS_W  = 23;

  // Returns {qp/6, qp%6} as a constant table, so no divider is built.
  function automatic logic [6:0] qp_split(input logic [5:0] qp);
    logic [6:0] r;
    r = '0;
    for (int i = 0; i < 52; i++) begin
      if (qp == 6'(i)) r = {4'(i / 6), 3'(i % 6)};
    end
    return r;
  endfunction

  // cls: 0 = both even, 1 = both odd, 2 = mixed
  function automatic logic [COEF_W-1:0] mf_lookup(input logic [2:0] qpm, input logic [1:0] cls);
    logic [COEF_W-1:0] r;
    r = '0;
    case (qpm)
      3'd0:    r = (cls == 2'd0) ? 14'd13107 : (cls == 2'd1) ? 14'd5243 : 14'd8066;
      3'd1:    r = (cls == 2'd0) ? 14'd11916 : (cls == 2'd1) ? 14'd4660 : 14'd7490;
      3'd2:    r = (cls == 2'd0) ? 14'd10082 : (cls == 2'd1) ? 14'd4194 : 14'd6554;
      3'd3:    r = (cls == 2'd0) ? 14'd9362  : (cls == 2'd1) ? 14'd3647 : 14'd5825;
      3'd4:    r = (cls == 2'd0) ? 14'd8192  : (cls == 2'd1) ? 14'd3355 : 14'd5243;
      default: r = (cls == 2'd0) ? 14'd7282  : (cls == 2'd1) ? 14'd2893 : 14'd4559;
    endcase
    return r;
  endfunction

  function automatic logic [OFS_W-1:0] round_offset(input logic [3:0] qpd, input logic intra);
    logic [OFS_W-1:0] r;
    r = '0;
    for (int i = 0; i < 9; i++) begin
      if (qpd == 4'(i)) r = intra ? OFS_W'((1 << (15 + i)) / 3) : OFS_W'((1 << (15 + i)) / 6);
    end
    return r;
  endfunction

  // Largest magnitude is 13107, so the low OUT_W bits of the shifted sum are exact.
  function automatic logic signed [OUT_W-1:0] quantize(input logic [PROD_W-1:0] prod,
                                                       input logic [3:0] qpd,
                                                       input logic intra,
                                                       input logic sign);
    logic [SUM_W-1:0]        sum;
    logic [SUM_W-1:0]        mag;
    logic [4:0]              qbits;
    logic signed [OUT_W-1:0] m;
    qbits = 5'd15 + {1'b0, qpd};
    sum   = {1'b0, prod} + SUM_W'(round_offset(qpd, intra));
    mag   = sum >> qbits;
    m     = mag[OUT_W-1:0];
    return sign ? -m : m;
  endfunction

  logic                    adv, in_xfer, out_xfer, rdy_en;
  logic [3:0]              pos;
  logic [5:0]              qp_l, qp_c, qp_eff;
  logic                    intra_l, intra_eff;
  logic [3:0]              qpd_eff;
  logic [2:0]              qpm_eff;
  logic [1:0]              cls;
  logic [DATA_W-1:0]       abs_w;
  logic [COEF_W-1:0]       mf;

  logic                    vld_p1, sign_p1, intra_p1, last_p1;
  logic [PROD_W-1:0]       prod_p1;
  logic [3:0]              qpd_p1;

  logic                    vld_p2, last_p2;
  logic signed [OUT_W-1:0] level_p2;
  logic [4:0]              nz_acc;

  assign adv      = out_ready || !vld_p2;
  assign in_ready = adv && rdy_en;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = vld_p2 && out_ready;

  // Position 0 uses its own freshly presented parameters, not the stale latch.
  assign qp_c      = (in_qp > 6'd51) ? 6'd51 : in_qp;
  assign qp_eff    = (pos == 4'd0) ? qp_c : qp_l;
  assign intra_eff = (pos == 4'd0) ? in_intra : intra_l;
  assign {qpd_eff, qpm_eff} = qp_split(qp_eff);
  assign mf        = mf_lookup(qpm_eff, cls);

  always_comb begin
    cls   = 2'd2;
    abs_w = in_coef[DATA_W-1] ? -in_coef : in_coef;
    if (!pos[2] && !pos[0]) cls = 2'd0;
    else if (pos[2] && pos[0]) cls = 2'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdy_en   <= 1'b0;
      pos      <= '0;
      qp_l     <= '0;
      intra_l  <= 1'b0;
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      last_p2  <= 1'b0;
      level_p2 <= '0;
      nz_acc   <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (in_xfer) begin
        pos <= pos + 4'd1;
        if (pos == 4'd0) begin
          qp_l    <= qp_c;
          intra_l <= in_intra;
        end
      end
      // S1 -> S2 boundary: round, shift and restore sign
      if (adv) begin
        vld_p1   <= in_xfer;
        vld_p2   <= vld_p1;
        last_p2  <= vld_p1 && last_p1;
        level_p2 <= quantize(prod_p1, qpd_p1, intra_p1, sign_p1);
      end
      if (out_xfer) begin
        nz_acc <= last_p2 ? 5'd0 : nz_acc + {4'd0, level_p2 != '0};
      end
    end
  end

  // Input -> S1 boundary: magnitude times MF
  always_ff @(posedge clk) begin
    if (adv) begin
      sign_p1  <= in_coef[DATA_W-1];
      prod_p1  <= PROD_W'(abs_w) * PROD_W'(mf);
      qpd_p1   <= qpd_eff;
      intra_p1 <= intra_eff;
      last_p1  <= (pos == 4'd15);
    end
  end

  assign out_valid = vld_p2;
  assign out_level = level_p2;
  assign out_last  = last_p2;
  assign out_nz    = last_p2 ? nz_acc + {4'd0, level_p2 != '0} : 5'd0;

endmodule
